// File: rtl/train_pkg.sv
// -----------------------------------------------------------------------------
// train_pkg
// Shared definitions for the train controller and its sensor front end:
// sensor count, sensor bit positions and default conditioning parameters.
// -----------------------------------------------------------------------------
package train_pkg;

   localparam int unsigned NUM_SENSORS = 4;

   localparam int unsigned S1_IDX = 0;
   localparam int unsigned S2_IDX = 1;
   localparam int unsigned S3_IDX = 2;
   localparam int unsigned S4_IDX = 3;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
   localparam int unsigned GLITCH_W_DEF        = 8;

endpackage : train_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One sensor bit: two-flop synchroniser, debounce counter, accepted level,
// registered rise/fall pulses and a saturating glitch counter.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   raw         unsynchronised sensor input
//   glitch_clr  synchronous clear of the glitch counter (wins over a glitch)
//   level       debounced level
//   rise        one-cycle pulse in the cycle level goes 0->1
//   fall        one-cycle pulse in the cycle level goes 1->0
//   glitch_cnt  saturating count of rejected bounces
//   glitch_evt  combinational: a bounce is being rejected at the next edge
// -----------------------------------------------------------------------------
module debounce_channel
   import train_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned GLITCH_W        = GLITCH_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                raw,
   input  logic                glitch_clr,
   output logic                level,
   output logic                rise,
   output logic                fall,
   output logic [GLITCH_W-1:0] glitch_cnt,
   output logic                glitch_evt
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_n;
   logic [CNT_W-1:0] cnt;

   // A bounce is rejected when the input returns to the accepted level
   // after at least one differing sample.
   always_comb begin
      glitch_evt = (sync_n == level) && (cnt != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_1 <= 1'b0;
         sync_n <= 1'b0;
         cnt    <= '0;
         level  <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_n <= sync_1;
         rise   <= 1'b0;
         fall   <= 1'b0;
         if (sync_n == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync_n;
            cnt   <= '0;
            rise  <= sync_n;
            fall  <= ~sync_n;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         glitch_cnt <= '0;
      end else if (glitch_clr) begin
         glitch_cnt <= '0;
      end else if (glitch_evt && (glitch_cnt != '1)) begin
         glitch_cnt <= glitch_cnt + 1'b1;
      end
   end

endmodule : debounce_channel

// File: rtl/sensor_conditioner.sv
// -----------------------------------------------------------------------------
// sensor_conditioner
// Front end for the train controller: synchronises and debounces the four raw
// track sensors, produces edge pulses and per-channel glitch statistics.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   raw_s       raw sensors (bit0=s1 .. bit3=s4)
//   glitch_clr  synchronous clear of all glitch counters and glitch_any
//   s_level     debounced levels for the controller's s1..s4
//   s_rise      one-cycle rising-edge pulses
//   s_fall      one-cycle falling-edge pulses
//   glitch_cnt  packed counters, channel n at [n*GLITCH_W +: GLITCH_W]
//   glitch_any  sticky flag, set by a glitch on any channel
// -----------------------------------------------------------------------------
module sensor_conditioner
   import train_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned GLITCH_W        = GLITCH_W_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_SENSORS-1:0]          raw_s,
   input  logic                            glitch_clr,
   output logic [NUM_SENSORS-1:0]          s_level,
   output logic [NUM_SENSORS-1:0]          s_rise,
   output logic [NUM_SENSORS-1:0]          s_fall,
   output logic [NUM_SENSORS*GLITCH_W-1:0] glitch_cnt,
   output logic                            glitch_any
);

   logic [NUM_SENSORS-1:0] glitch_evt;

   for (genvar n = 0; n < NUM_SENSORS; n++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .GLITCH_W        (GLITCH_W)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .raw        (raw_s[n]),
         .glitch_clr (glitch_clr),
         .level      (s_level[n]),
         .rise       (s_rise[n]),
         .fall       (s_fall[n]),
         .glitch_cnt (glitch_cnt[n*GLITCH_W +: GLITCH_W]),
         .glitch_evt (glitch_evt[n])
      );
   end

   // Clear has priority over a coincident glitch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         glitch_any <= 1'b0;
      end else if (glitch_clr) begin
         glitch_any <= 1'b0;
      end else if (|glitch_evt) begin
         glitch_any <= 1'b1;
      end
   end

endmodule : sensor_conditioner

// File: tb/tb_sensor_conditioner.sv
module tb_sensor_conditioner;

   localparam int unsigned DC   = 4;
   localparam int unsigned GW   = 8;
   localparam int unsigned NS   = 4;
   localparam int unsigned GMAX = (1 << GW) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [NS-1:0]    raw_s = '0;
   logic             glitch_clr = 1'b0;
   logic [NS-1:0]    s_level;
   logic [NS-1:0]    s_rise;
   logic [NS-1:0]    s_fall;
   logic [NS*GW-1:0] glitch_cnt;
   logic             glitch_any;

   int checks   = 0;
   int failures = 0;

   // Reference model: raw samples pass through a two-sample delay; a new level
   // is accepted once DC consecutive delayed samples differ from the current
   // level; a differing run that ends early is a glitch.
   logic [NS-1:0] m_d1, m_d2, m_lvl, m_rise, m_fall;
   int            m_run  [NS];
   int            m_gcnt [NS];
   bit            m_any;

   sensor_conditioner #(
      .DEBOUNCE_CYCLES (DC),
      .GLITCH_W        (GW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .raw_s      (raw_s),
      .glitch_clr (glitch_clr),
      .s_level    (s_level),
      .s_rise     (s_rise),
      .s_fall     (s_fall),
      .glitch_cnt (glitch_cnt),
      .glitch_any (glitch_any)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_any = 0;
      for (int ch = 0; ch < NS; ch++) begin
         m_run[ch]  = 0;
         m_gcnt[ch] = 0;
      end
   endtask

   task automatic model_edge();
      logic [NS-1:0] samp;
      bit g;
      samp = m_d2;
      g = 0;
      m_rise = '0;
      m_fall = '0;
      for (int ch = 0; ch < NS; ch++) begin
         if (samp[ch] != m_lvl[ch]) begin
            m_run[ch]++;
            if (m_run[ch] == DC) begin
               m_lvl[ch] = samp[ch];
               if (samp[ch]) m_rise[ch] = 1'b1;
               else          m_fall[ch] = 1'b1;
               m_run[ch] = 0;
            end
         end else begin
            if (m_run[ch] != 0) begin
               g = 1;
               if (m_gcnt[ch] < GMAX) m_gcnt[ch]++;
            end
            m_run[ch] = 0;
         end
      end
      if (g) m_any = 1;
      if (glitch_clr) begin
         m_any = 0;
         for (int ch = 0; ch < NS; ch++) m_gcnt[ch] = 0;
      end
      m_d2 = m_d1;
      m_d1 = raw_s;
   endtask

   task automatic compare_all(input string tag);
      logic [NS*GW-1:0] exp_g;
      for (int ch = 0; ch < NS; ch++) exp_g[ch*GW +: GW] = GW'(m_gcnt[ch]);
      check({tag, ".level"}, 32'(s_level), 32'(m_lvl));
      check({tag, ".rise"},  32'(s_rise),  32'(m_rise));
      check({tag, ".fall"},  32'(s_fall),  32'(m_fall));
      check({tag, ".gcnt"},  32'(glitch_cnt), 32'(exp_g));
      check({tag, ".gany"},  32'(glitch_any), 32'(m_any));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (rst) model_edge();
      else     model_reset();
      #1;
      compare_all(tag);
   endtask

   task automatic ticks(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   initial begin
      model_reset();

      // 1. Reset with all sensors high, then release.
      raw_s = 4'b1111;
      ticks("rst_hold", 3);
      check("rst_level_zero", 32'(s_level), 32'h0);
      rst = 1'b1;
      ticks("rst_exit", 5);
      check("rst_level_pre", 32'(s_level), 32'h0);
      tick("rst_exit6");
      check("rst_level_6th", 32'(s_level), 32'hF);
      check("rst_rise_6th",  32'(s_rise),  32'hF);
      tick("rst_exit7");
      check("rst_rise_width", 32'(s_rise), 32'h0);
      raw_s = 4'b0000;
      ticks("settle0", 10);

      // 2. Clean press on s1.
      raw_s[0] = 1'b1;
      ticks("press", 5);
      check("press_level_early", 32'(s_level[0]), 32'h0);
      tick("press6");
      check("press_level", 32'(s_level[0]), 32'h1);
      check("press_rise",  32'(s_rise[0]),  32'h1);
      check("press_fall",  32'(s_fall),     32'h0);
      check("press_gcnt0", 32'(glitch_cnt[0 +: GW]), 32'h0);
      tick("press7");
      check("press_rise_width", 32'(s_rise[0]), 32'h0);
      raw_s[0] = 1'b0;
      ticks("settle1", 10);

      // 3. Two-cycle bounce on s2 is rejected.
      raw_s[1] = 1'b1;
      ticks("bounce_hi", 2);
      raw_s[1] = 1'b0;
      ticks("bounce_lo", 6);
      check("bounce_level", 32'(s_level[1]), 32'h0);
      check("bounce_gcnt1", 32'(glitch_cnt[GW +: GW]), 32'h1);
      check("bounce_gany",  32'(glitch_any), 32'h1);

      // 4. Saturation on s3, then clear coincident with a glitch.
      for (int i = 0; i < 260; i++) begin
         raw_s[2] = 1'b1;
         tick("sat_hi");
         raw_s[2] = 1'b0;
         tick("sat_lo");
      end
      ticks("sat_flush", 4);
      check("sat_gcnt2", 32'(glitch_cnt[2*GW +: GW]), 32'(GMAX));
      raw_s[2] = 1'b1;
      tick("clr_hi");
      raw_s[2] = 1'b0;
      ticks("clr_lo", 2);
      glitch_clr = 1'b1;
      tick("clr_edge");
      glitch_clr = 1'b0;
      check("clr_gcnt_all", 32'(glitch_cnt), 32'h0);
      check("clr_gany",     32'(glitch_any), 32'h0);
      ticks("clr_after", 4);

      // 5. Simultaneous rise and fall on s2 and s4.
      raw_s = 4'b1010;
      ticks("sim_rise", 5);
      tick("sim_rise6");
      check("sim_rise", 32'(s_rise),  32'hA);
      check("sim_lvl",  32'(s_level), 32'hA);
      ticks("sim_hold", 4);
      raw_s = 4'b0000;
      ticks("sim_fall", 5);
      tick("sim_fall6");
      check("sim_fall",   32'(s_fall),  32'hA);
      check("sim_lvl0",   32'(s_level), 32'h0);
      check("sim_rise_0", 32'(s_rise),  32'h0);

      // 6. Reset in the middle of a debounce on s4, with s1 already high.
      raw_s = 4'b0001;
      ticks("mid_pre", 8);
      check("mid_pre_lvl", 32'(s_level), 32'h1);
      raw_s = 4'b1001;
      ticks("mid_cnt", 4);
      rst = 1'b0;
      #1;
      model_reset();
      check("mid_async_lvl", 32'(s_level), 32'h0);
      compare_all("mid_async");
      ticks("mid_hold", 2);
      rst = 1'b1;
      ticks("mid_exit", 5);
      check("mid_lvl_early", 32'(s_level), 32'h0);
      tick("mid_exit6");
      check("mid_lvl", 32'(s_level), 32'h9);
      check("mid_rise", 32'(s_rise), 32'h9);

      // Randomised traffic: per-bit flips with occasional clears.
      for (int i = 0; i < 3000; i++) begin
         for (int ch = 0; ch < NS; ch++)
            if ($urandom_range(7) == 0) raw_s[ch] = ~raw_s[ch];
         glitch_clr = ($urandom_range(63) == 0);
         tick("rand");
      end
      glitch_clr = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sensor_conditioner
